// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave with an internal word-addressed memory.
//
// Terminating slave behind a fabric port. Each NONSEQ/SEQ beat is handled on its own and
// receives WAIT wait states. Writes use byte lanes derived from hsize and the low address bits.
//
// Optional feature: define AHB_SRAM_SLAVE_ERR_RESP_EN to answer illegal transfers with a
// two-cycle ERROR response. When it is left undefined, illegal transfers complete as OKAY:
// writes are dropped and reads return 0.
//
// Ports:
//   hclk, hreset            clock and synchronous active-high reset
//   hsel, htrans, hready    address-phase qualification (accept = hsel & hready & htrans[1])
//   haddr, hwrite, hsize    address-phase controls, latched on accept
//   hburst, hprot, hmastlock  accepted but not used
//   hwdata                  write data, sampled on the edge that completes the data phase
//   hrdata, hresp, hreadyout  data-phase response
module ahb_sram_slave #(
    parameter int unsigned      HADDR = 32,
    parameter int unsigned      HDATA = 32,
    parameter int unsigned      DEPTH = 256,
    parameter logic [HADDR-1:0] BASE  = '0,
    parameter int unsigned      WAIT  = 0
) (
    input  logic             hclk,
    input  logic             hreset,
    input  logic             hsel,
    input  logic [1:0]       htrans,
    input  logic [2:0]       hburst,
    input  logic [2:0]       hsize,
    input  logic [3:0]       hprot,
    input  logic             hmastlock,
    input  logic [HADDR-1:0] haddr,
    input  logic             hwrite,
    input  logic [HDATA-1:0] hwdata,
    input  logic             hready,
    output logic [HDATA-1:0] hrdata,
    output logic             hresp,
    output logic             hreadyout
);
    localparam int unsigned NB    = HDATA / 8;
    localparam int unsigned OFFW  = $clog2(NB);
    localparam int unsigned IDXW  = $clog2(DEPTH);
    localparam logic [63:0] LIMIT = 64'(BASE) + 64'(DEPTH) * 64'(NB);

    typedef enum logic [1:0] {StIdle, StData, StErr1, StErr2} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             write_q, write_d;
    logic             illegal_q, illegal_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [NB-1:0]    be_q, be_d;
    logic [HDATA-1:0] hrdata_q;
    logic [HDATA-1:0] mem_q [DEPTH];

    logic             ready_int;
    logic             accept;
    logic             addr_illegal;
    logic             wr_en;
    logic             rd_phase;
    logic [HADDR-1:0] rel_addr;
    logic [NB-1:0]    be_new;

    logic unused_inputs;
    assign unused_inputs = ^{hburst, hprot, hmastlock, rel_addr};

    always_comb begin
        unique case (state_q)
            StData:  ready_int = (cnt_q == 4'd0);
            StErr1:  ready_int = 1'b0;
            default: ready_int = 1'b1;
        endcase
    end

    // Only sample a new address phase when our own data phase is also finishing.
    assign accept = hsel & hready & htrans[1] & ready_int;

    // Address decode and legality check for the beat currently on the bus.
    always_comb begin
        rel_addr     = haddr - BASE;
        addr_illegal = (64'(haddr) < 64'(BASE)) || (64'(haddr) >= LIMIT) ||
                       (int'(hsize) > int'(OFFW)) ||
                       ((int'(haddr[OFFW-1:0]) & ((1 << hsize) - 1)) != 0);
        // Lane b is enabled when it falls inside the aligned 2^hsize-byte block at haddr.
        for (int b = 0; b < int'(NB); b++) begin
            be_new[b] = ((b >> hsize) == (int'(haddr[OFFW-1:0]) >> hsize));
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        illegal_d = illegal_q;
        idx_d     = idx_q;
        be_d      = be_q;
        unique case (state_q)
            StData: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = StIdle;
                end
            end
            StErr1:  state_d = StErr2;
            StErr2:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            write_d   = hwrite;
            illegal_d = addr_illegal;
            idx_d     = rel_addr[OFFW +: IDXW];
            be_d      = be_new;
            cnt_d     = 4'(WAIT);
`ifdef AHB_SRAM_SLAVE_ERR_RESP_EN
            state_d   = addr_illegal ? StErr1 : StData;
`else
            state_d   = StData;
`endif
        end
    end

    assign wr_en    = (state_q == StData) && (cnt_q == 4'd0) && write_q && !illegal_q;
    assign rd_phase = (state_q == StData) && !write_q;

    always_comb begin
        hreadyout = ready_int;
        if (rd_phase) begin
            hrdata = illegal_q ? '0 : mem_q[idx_q];
        end else begin
            hrdata = hrdata_q;
        end
`ifdef AHB_SRAM_SLAVE_ERR_RESP_EN
        hresp = (state_q == StErr1) || (state_q == StErr2);
`else
        hresp = 1'b0;
`endif
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            write_q   <= 1'b0;
            illegal_q <= 1'b0;
            idx_q     <= '0;
            be_q      <= '0;
            hrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            write_q   <= write_d;
            illegal_q <= illegal_d;
            idx_q     <= idx_d;
            be_q      <= be_d;
            hrdata_q  <= hrdata;
        end
    end

    // Array is never cleared; a reset in the middle of a write phase drops that write.
    always_ff @(posedge hclk) begin
        if (!hreset && wr_en) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
    localparam logic [1:0] TIdle   = 2'd0;
    localparam logic [1:0] TNonseq = 2'd2;
    localparam logic [1:0] TSeq    = 2'd3;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;

    logic [31:0] rd [3];
    logic        rs [3];
    logic        ro [3];
    int          sel;

    logic        ready_bus;
    logic        resp_bus;
    logic [31:0] rdata_bus;

    int total = 0;
    int bad   = 0;

    // Beat tables for run_seq and the values it observed per beat.
    logic [31:0] s_addr  [8];
    logic        s_wr    [8];
    logic [2:0]  s_size  [8];
    logic [31:0] s_wdata [8];
    logic [1:0]  s_trans [8];
    int          s_n;
    logic [31:0] r_rdata [8];
    logic        r_resp_first [8];
    logic        r_resp_last  [8];
    int          r_waits [8];

    always #5 clk = ~clk;

    assign ready_bus = ro[sel];
    assign resp_bus  = rs[sel];
    assign rdata_bus = rd[sel];

    ahb_sram_slave #(.WAIT(0)) u_w0 (
        .hclk(clk), .hreset(hreset), .hsel(hsel && sel == 0), .htrans(htrans),
        .hburst(hburst), .hsize(hsize), .hprot(hprot), .hmastlock(hmastlock),
        .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready(ready_bus),
        .hrdata(rd[0]), .hresp(rs[0]), .hreadyout(ro[0])
    );

    ahb_sram_slave #(.WAIT(2)) u_w2 (
        .hclk(clk), .hreset(hreset), .hsel(hsel && sel == 1), .htrans(htrans),
        .hburst(hburst), .hsize(hsize), .hprot(hprot), .hmastlock(hmastlock),
        .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready(ready_bus),
        .hrdata(rd[1]), .hresp(rs[1]), .hreadyout(ro[1])
    );

    ahb_sram_slave #(.WAIT(3)) u_w3 (
        .hclk(clk), .hreset(hreset), .hsel(hsel && sel == 2), .htrans(htrans),
        .hburst(hburst), .hsize(hsize), .hprot(hprot), .hmastlock(hmastlock),
        .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready(ready_bus),
        .hrdata(rd[2]), .hresp(rs[2]), .hreadyout(ro[2])
    );

    task automatic set_beat(input int i, input logic [31:0] a, input logic w,
                            input logic [2:0] sz, input logic [31:0] d, input logic [1:0] t);
        s_addr[i]  = a;
        s_wr[i]    = w;
        s_size[i]  = sz;
        s_wdata[i] = d;
        s_trans[i] = t;
    endtask

    // Pipelined master: beat i's address phase overlaps beat i-1's data phase.
    task automatic run_seq();
        int waits;
        logic first_resp;
        for (int i = 0; i <= s_n; i++) begin
            if (i < s_n) begin
                hsel   = 1'b1;
                haddr  = s_addr[i];
                hwrite = s_wr[i];
                hsize  = s_size[i];
                htrans = s_trans[i];
            end else begin
                hsel   = 1'b0;
                htrans = TIdle;
            end
            if (i > 0) hwdata = s_wdata[i-1];
            waits = 0;
            @(negedge clk);
            first_resp = resp_bus;
            while (!ready_bus && waits < 40) begin
                waits++;
                @(negedge clk);
            end
            if (!ready_bus) begin
                total++;
                bad++;
                $display("FAIL seq_timeout beat=%0d got hreadyout=0 need 1", i);
            end
            if (i > 0) begin
                r_rdata[i-1]      = rdata_bus;
                r_resp_first[i-1] = first_resp;
                r_resp_last[i-1]  = resp_bus;
                r_waits[i-1]      = waits;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        hreset = 1'b1; hsel = 1'b0; htrans = TIdle; hburst = 3'd0; hsize = 3'd2;
        hprot = 4'd0; hmastlock = 1'b0; haddr = '0; hwrite = 1'b0; hwdata = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1 hreset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (ro[k] !== 1'b1) begin bad++; $display("FAIL reset_ready dut=%0d got=%b exp=1", k, ro[k]); end
            total++;
            if (rs[k] !== 1'b0) begin bad++; $display("FAIL reset_resp dut=%0d got=%b exp=0", k, rs[k]); end
            total++;
            if (rd[k] !== 32'h0) begin bad++; $display("FAIL reset_rdata dut=%0d got=%h exp=0", k, rd[k]); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        sel = 0; hburst = 3'd0;
        set_beat(0, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, TNonseq);
        set_beat(1, 32'h10, 1'b0, 3'd2, 32'h0, TNonseq);
        s_n = 2;
        run_seq();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (r_waits[i] !== 0) begin bad++; $display("FAIL b2b_waits beat=%0d got=%0d exp=0", i, r_waits[i]); end
        end
        total++;
        if (r_rdata[1] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL b2b_rdata got=%h exp=deadbeef", r_rdata[1]);
        end
    endtask

    task automatic test_wait_states();
        sel = 1; hburst = 3'd0;
        set_beat(0, 32'h0, 1'b1, 3'd2, 32'hCAFEF00D, TNonseq);
        set_beat(1, 32'h0, 1'b0, 3'd2, 32'h0, TNonseq);
        s_n = 2;
        run_seq();
        total++;
        if (r_waits[1] !== 2) begin bad++; $display("FAIL wait_count got=%0d exp=2", r_waits[1]); end
        total++;
        if (r_rdata[1] !== 32'hCAFEF00D) begin
            bad++; $display("FAIL wait_rdata got=%h exp=cafef00d", r_rdata[1]);
        end
    endtask

    task automatic test_byte_write();
        sel = 0; hburst = 3'd0;
        set_beat(0, 32'h10, 1'b1, 3'd2, 32'h11223344, TNonseq);
        // Byte 0xAA rides on lane 3 for address 0x13; lane 0 carries junk that must be masked.
        set_beat(1, 32'h13, 1'b1, 3'd0, 32'hAA0000AA, TNonseq);
        set_beat(2, 32'h10, 1'b0, 3'd2, 32'h0, TNonseq);
        set_beat(3, 32'h10, 1'b1, 3'd1, 32'h7777BEEF, TNonseq);
        set_beat(4, 32'h10, 1'b0, 3'd2, 32'h0, TNonseq);
        s_n = 5;
        run_seq();
        total++;
        if (r_rdata[2] !== 32'hAA223344) begin
            bad++; $display("FAIL byte_write got=%h exp=aa223344", r_rdata[2]);
        end
        total++;
        if (r_rdata[4] !== 32'hAA22BEEF) begin
            bad++; $display("FAIL half_write got=%h exp=aa22beef", r_rdata[4]);
        end
    endtask

    task automatic test_burst(input int k, input int exp_wait);
        logic [31:0] exp_rd [4];
        exp_rd[0] = 32'd3; exp_rd[1] = 32'd4; exp_rd[2] = 32'd1; exp_rd[3] = 32'd2;
        sel = k; hburst = 3'd3;
        set_beat(0, 32'h20, 1'b1, 3'd2, 32'd1, TNonseq);
        set_beat(1, 32'h24, 1'b1, 3'd2, 32'd2, TSeq);
        set_beat(2, 32'h28, 1'b1, 3'd2, 32'd3, TSeq);
        set_beat(3, 32'h2C, 1'b1, 3'd2, 32'd4, TSeq);
        set_beat(4, 32'h28, 1'b0, 3'd2, 32'h0, TNonseq);
        set_beat(5, 32'h2C, 1'b0, 3'd2, 32'h0, TSeq);
        set_beat(6, 32'h20, 1'b0, 3'd2, 32'h0, TSeq);
        set_beat(7, 32'h24, 1'b0, 3'd2, 32'h0, TSeq);
        s_n = 8;
        run_seq();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (r_rdata[4+i] !== exp_rd[i]) begin
                bad++; $display("FAIL burst_rdata dut=%0d beat=%0d got=%h exp=%h", k, i, r_rdata[4+i], exp_rd[i]);
            end
            total++;
            if (r_waits[4+i] !== exp_wait) begin
                bad++; $display("FAIL burst_waits dut=%0d beat=%0d got=%0d exp=%0d", k, i, r_waits[4+i], exp_wait);
            end
        end
        hburst = 3'd0;
    endtask

    task automatic test_error();
        sel = 0; hburst = 3'd0;
        // hrdata currently holds 2 from the last burst beat.
        set_beat(0, 32'h400, 1'b0, 3'd2, 32'h0, TNonseq);
        s_n = 1;
        run_seq();
`ifdef AHB_SRAM_SLAVE_ERR_RESP_EN
        total++;
        if (r_waits[0] !== 1) begin bad++; $display("FAIL err_waits got=%0d exp=1", r_waits[0]); end
        total++;
        if (r_resp_first[0] !== 1'b1) begin bad++; $display("FAIL err_resp1 got=%b exp=1", r_resp_first[0]); end
        total++;
        if (r_resp_last[0] !== 1'b1) begin bad++; $display("FAIL err_resp2 got=%b exp=1", r_resp_last[0]); end
        total++;
        if (r_rdata[0] !== 32'd2) begin bad++; $display("FAIL err_rdata got=%h exp=2", r_rdata[0]); end
`else
        total++;
        if (r_waits[0] !== 0) begin bad++; $display("FAIL oor_waits got=%0d exp=0", r_waits[0]); end
        total++;
        if (r_resp_last[0] !== 1'b0) begin bad++; $display("FAIL oor_resp got=%b exp=0", r_resp_last[0]); end
        total++;
        if (r_rdata[0] !== 32'h0) begin bad++; $display("FAIL oor_rdata got=%h exp=0", r_rdata[0]); end
`endif
        // Misaligned word write and oversize write must leave memory untouched.
        set_beat(0, 32'h22, 1'b1, 3'd2, 32'hFFFFFFFF, TNonseq);
        set_beat(1, 32'h24, 1'b1, 3'd3, 32'hFFFFFFFF, TNonseq);
        set_beat(2, 32'h20, 1'b0, 3'd2, 32'h0, TNonseq);
        set_beat(3, 32'h24, 1'b0, 3'd2, 32'h0, TNonseq);
        s_n = 4;
        run_seq();
        total++;
        if (r_rdata[2] !== 32'd1) begin bad++; $display("FAIL illegal_wr0 got=%h exp=1", r_rdata[2]); end
        total++;
        if (r_rdata[3] !== 32'd2) begin bad++; $display("FAIL illegal_wr1 got=%h exp=2", r_rdata[3]); end
        total++;
        if (r_resp_last[3] !== 1'b0) begin bad++; $display("FAIL legal_resp got=%b exp=0", r_resp_last[3]); end
    endtask

    task automatic test_reset_mid_write();
        sel = 2; hburst = 3'd0;
        set_beat(0, 32'h40, 1'b1, 3'd2, 32'h0BADF00D, TNonseq);
        set_beat(1, 32'h40, 1'b0, 3'd2, 32'h0, TNonseq);
        s_n = 2;
        run_seq();
        total++;
        if (r_rdata[1] !== 32'h0BADF00D) begin
            bad++; $display("FAIL rst_preload got=%h exp=0badf00d", r_rdata[1]);
        end
        hsel = 1'b1; haddr = 32'h40; hwrite = 1'b1; hsize = 3'd2; htrans = TNonseq;
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = TIdle; hwdata = 32'h55555555;
        @(negedge clk);
        total++;
        if (ready_bus !== 1'b0) begin bad++; $display("FAIL rst_wait1 got=%b exp=0", ready_bus); end
        @(posedge clk);
        #1 hreset = 1'b1;
        @(posedge clk);
        #1 hreset = 1'b0;
        @(negedge clk);
        total++;
        if (ro[2] !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", ro[2]); end
        total++;
        if (rs[2] !== 1'b0) begin bad++; $display("FAIL rst_mid_resp got=%b exp=0", rs[2]); end
        total++;
        if (rd[2] !== 32'h0) begin bad++; $display("FAIL rst_mid_rdata got=%h exp=0", rd[2]); end
        @(posedge clk);
        #1;
        set_beat(0, 32'h40, 1'b0, 3'd2, 32'h0, TNonseq);
        s_n = 1;
        run_seq();
        total++;
        if (r_rdata[0] !== 32'h0BADF00D) begin
            bad++; $display("FAIL rst_dropped_write got=%h exp=0badf00d", r_rdata[0]);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_byte_write();
        test_burst(0, 0);
        test_burst(1, 2);
        test_error();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
